seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexes NUM_DIGITS BCD digits onto one shared seven_segment decoder and
//  a common-anode display. Drives the decoder nibble and the active-low digit anodes.
//  Blanks every digit slot briefly to prevent ghosting and suppresses leading zeros.
//  Takes new values through a shadow register that commits only at a frame boundary,
//  so a partial value is never shown.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned, >=2; digit 0 = least significant, value[3:0]
//  REFRESH_DIV   50000  clk cycles per digit slot, >=2
//  BLANK_CYCLES  500    cycles at slot start with all anodes off, 0..REFRESH_DIV-1
// PORTS
//  clk        in   1              system clock, rising edge
//  reset      in   1              asynchronous, active-high reset
//  load       in   1              1-cycle strobe: capture value into shadow register
//  value      in   4*NUM_DIGITS   packed BCD digits; nibble i = digit i
//  lz_en      in   1              1 = blank leading zeros (digit 0 never blanked)
//  num        out  4              nibble to seven_segment.num; 4'hF = blank (decoder default)
//  an         out  NUM_DIGITS     active-low anode enables, at most one bit low
//  digit_idx  out  $clog2(NUM_DIGITS)  digit slot currently being scanned
//  frame_done out  1              1-cycle pulse when the last slot ends (wrap to digit 0)
// BEHAVIOUR
//  Reset (async assert, sync release): cnt=0, digit_idx=0, an=all 1, num=4'hF,
//    frame_done=0, disp=0, shadow=0, pending=0.
//  Slot counter cnt runs 0..REFRESH_DIV-1 and wraps. At the wrap, digit_idx increments,
//    going from NUM_DIGITS-1 back to 0.
//  All outputs are registered from next state. Values are aligned to the cnt value
//    present in the same cycle.
//  States per slot: BLANK (cnt < BLANK_CYCLES): an=all 1, num=4'hF.
//    SHOW (cnt >= BLANK_CYCLES): an[digit_idx]=0, other anodes 1, num=eff digit.
//    With BLANK_CYCLES=0 there is no BLANK state.
//  eff digit: disp nibble digit_idx. It is forced to 4'hF when lz_en=1,
//    digit_idx != 0, and disp nibbles digit_idx..NUM_DIGITS-1 are all zero.
//  Nibbles >9 pass through unchanged; the decoder blanks them.
//  load=1: shadow<=value, pending<=1. A second load before commit overwrites it
//    (last load wins).
//  Frame boundary = the cycle where cnt=REFRESH_DIV-1 and digit_idx=NUM_DIGITS-1.
//    On the next edge: digit_idx=0, cnt=0, frame_done=1 for exactly 1 cycle.
//    If pending or load, disp takes the new value; load same cycle has priority and
//    supplies value directly. pending then clears.
//  New disp is first visible in digit 0's SHOW state after BLANK_CYCLES.
//  lz_en is sampled live every cycle; it is not shadowed.
//  Reset mid-slot or mid-frame: all anodes off immediately (async). Pending load is lost.
// TESTING  (bench params NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
//  Reset release, no load -> an=4'b1111 for cycles 0-1; then an=4'b1110, num=0
//    for cycles 2-7; digit 1 slot starts at cycle 8 (an=1111 for 2 cycles).
//  load value=16'h1234 at cycle 3, lz_en=0 -> num stays 0 until frame_done (cycle 32);
//    next frame shows digit0=4, 1=3, 2=2, 3=1 with an 1110/1101/1011/0111.
//  value=16'h0050, lz_en=1 -> digits 3,2 num=F; digit1=5; digit0=0.
//    value=16'h0000 -> only digit0 shows 0.
//  Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows 2222 only.
//    A load on the boundary cycle commits in that same frame wrap.
//  Assert reset at cnt=5 of slot 2 -> same cycle an=1111, num=F, digit_idx=0;
//    pending shadow discarded; after release, restart from cycle 0.
//  Every cycle: $countones(~an)<=1, and frame_done is high exactly once
//    per 32 cycles.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexes NUM_DIGITS packed BCD digits onto one shared seven-segment
// decoder driving a common-anode display. Each digit slot starts with a short
// all-anodes-off window to suppress ghosting, and leading zeros can be blanked.
// New values go into a shadow register and only reach the display at a frame
// boundary, so a half-updated number is never shown.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   load        1-cycle strobe, captures value into the shadow register
//   value       packed BCD digits, nibble i = digit i (digit 0 = LSD)
//   lz_en       1 = blank leading zeros (digit 0 is never blanked), live input
//   num         nibble to the decoder; 4'hF blanks the segments
//   an          active-low anode enables, at most one bit low
//   digit_idx   digit slot currently being scanned
//   frame_done  1-cycle pulse on the first cycle of a new frame
//
// State | meaning
// ------+---------------------------------------------------------------
// BLANK | cnt < BLANK_CYCLES: all anodes off, num = 4'hF
// SHOW  | cnt >= BLANK_CYCLES: anode of digit_idx on, num = effective digit
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic                          lz_en,
    output logic [3:0]                    num,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx_n;
    logic [4*NUM_DIGITS-1:0] disp, disp_n;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_n;
    logic                    pending, pending_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [3:0]              num_n;
    logic                    frame_done_n;
    logic                    slot_end;
    logic                    boundary;
    logic                    zeros;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [3:0]              nib;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            digit_idx  <= '0;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            an         <= '1;
            num        <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            digit_idx  <= idx_n;
            disp       <= disp_n;
            shadow     <= shadow_n;
            pending    <= pending_n;
            an         <= an_n;
            num        <= num_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        slot_end     = (cnt == CNT_MAX);
        boundary     = slot_end && (digit_idx == IDX_MAX);
        cnt_n        = slot_end ? '0 : cnt + 1'b1;
        idx_n        = digit_idx;
        disp_n       = disp;
        shadow_n     = shadow;
        pending_n    = pending;
        frame_done_n = boundary;
        zeros        = 1'b1;
        zero_from    = '0;
        an_n         = '1;
        num_n        = 4'hF;

        if (slot_end)
            idx_n = (digit_idx == IDX_MAX) ? '0 : digit_idx + 1'b1;

        // A load on the boundary cycle bypasses the shadow and commits now.
        if (boundary) begin
            if (load)
                disp_n = value;
            else if (pending)
                disp_n = shadow;
            if (load)
                shadow_n = value;
            pending_n = 1'b0;
        end else if (load) begin
            shadow_n  = value;
            pending_n = 1'b1;
        end

        state_n = (int'(cnt_n) < BLANK_CYCLES) ? ST_BLANK : ST_SHOW;

        // zero_from[i] = nibbles i..NUM_DIGITS-1 of the next display value are all zero
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeros        = zeros && (disp_n[4*i +: 4] == 4'h0);
            zero_from[i] = zeros;
        end

        nib = disp_n[{idx_n, 2'b00} +: 4];

        // Outputs are built from next-state values so they line up with cnt.
        if (state_n == ST_SHOW) begin
            an_n[idx_n] = 1'b0;
            if (lz_en && (idx_n != '0) && zero_from[idx_n])
                num_n = 4'hF;
            else
                num_n = nib;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        lz_en;
    logic [3:0]  num;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .lz_en     (lz_en),
        .num       (num),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    int          checks = 0;
    int          fails  = 0;
    int          mt;
    logic [15:0] mdisp;
    logic [15:0] mshadow;
    logic        mpend;
    logic [10:0] sb[$];
    logic [10:0] e;

    // Expected {an, num, digit_idx, frame_done} for cycle t after reset release.
    function automatic logic [10:0] exp_at(int t, logic [15:0] d, logic lz);
        int         c  = t % RD;
        int         s  = (t / RD) % ND;
        logic [3:0] a  = 4'hF;
        logic [3:0] n  = 4'hF;
        logic       fd = (t > 0) && (t % FRAME == 0);
        if (c >= BC) begin
            a = ~(4'b0001 << s);
            n = d[s*4 +: 4];
            if (lz && s != 0 && (d >> (s*4)) == 16'h0)
                n = 4'hF;
        end
        return {a, n, 2'(s), fd};
    endfunction

    function automatic void model_reset();
        mt      = 0;
        mdisp   = '0;
        mshadow = '0;
        mpend   = 1'b0;
        sb.delete();
    endfunction

    // Called at a negedge: drives inputs for the current cycle, advances the
    // model across the coming posedge, queues the expected outputs of the next
    // cycle and returns at that cycle's negedge.
    task automatic drive_cycle(input logic ld, input logic [15:0] val);
        load  = ld;
        value = val;
        if (mt % FRAME == FRAME - 1) begin
            if (ld)
                mdisp = val;
            else if (mpend)
                mdisp = mshadow;
            mpend = 1'b0;
        end else if (ld) begin
            mshadow = val;
            mpend   = 1'b1;
        end
        mt++;
        sb.push_back(exp_at(mt, mdisp, lz_en));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b0;
        value = '0;
        lz_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({an, num, digit_idx, frame_done} !== {4'hF, 4'hF, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_hold got an=%b num=%h idx=%0d fd=%b exp an=1111 num=f idx=0 fd=0",
                     an, num, digit_idx, frame_done);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb.push_back(exp_at(0, mdisp, lz_en));
        e = sb.pop_front();
        checks++;
        if ({an, num, digit_idx, frame_done} !== e) begin
            fails++;
            $display("FAIL reset_release got %b exp %b", {an, num, digit_idx, frame_done}, e);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, 16'h0);
            e = sb.pop_front();
            checks++;
            if ({an, num, digit_idx, frame_done} !== e) begin
                fails++;
                $display("FAIL idle t=%0d got an=%b num=%h idx=%0d fd=%b exp an=%b num=%h idx=%0d fd=%b",
                         mt, an, num, digit_idx, frame_done, e[10:7], e[6:3], e[2:1], e[0]);
            end
            checks++;
            if ($countones(~an) > 1) begin
                fails++;
                $display("FAIL idle_onehot t=%0d got an=%b exp at most one low", mt, an);
            end
        end
    endtask

    task automatic test_load();
        lz_en = 1'b0;
        for (int i = 0; i < 70; i++) begin
            drive_cycle(i == 3, 16'h1234);
            e = sb.pop_front();
            checks++;
            if ({an, num, digit_idx, frame_done} !== e) begin
                fails++;
                $display("FAIL load t=%0d got an=%b num=%h idx=%0d fd=%b exp an=%b num=%h idx=%0d fd=%b",
                         mt, an, num, digit_idx, frame_done, e[10:7], e[6:3], e[2:1], e[0]);
            end
            checks++;
            if ($countones(~an) > 1) begin
                fails++;
                $display("FAIL load_onehot t=%0d got an=%b exp at most one low", mt, an);
            end
        end
    endtask

    task automatic test_leading_zero();
        lz_en = 1'b1;
        for (int i = 0; i < 70; i++) begin
            drive_cycle(i == 0, 16'h0050);
            e = sb.pop_front();
            checks++;
            if ({an, num, digit_idx, frame_done} !== e) begin
                fails++;
                $display("FAIL lz_0050 t=%0d got an=%b num=%h idx=%0d fd=%b exp an=%b num=%h idx=%0d fd=%b",
                         mt, an, num, digit_idx, frame_done, e[10:7], e[6:3], e[2:1], e[0]);
            end
        end
        for (int i = 0; i < 90; i++) begin
            lz_en = (i < 60);
            drive_cycle(i == 0, 16'h0000);
            e = sb.pop_front();
            checks++;
            if ({an, num, digit_idx, frame_done} !== e) begin
                fails++;
                $display("FAIL lz_0000 t=%0d lz=%b got an=%b num=%h idx=%0d fd=%b exp an=%b num=%h idx=%0d fd=%b",
                         mt, lz_en, an, num, digit_idx, frame_done, e[10:7], e[6:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        ld;
        logic [15:0] v;
        lz_en = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ld = (i < 32) && ((mt % FRAME == 4) || (mt % FRAME == 8));
            v  = (mt % FRAME == 4) ? 16'h1111 : 16'h2222;
            drive_cycle(ld, v);
            e = sb.pop_front();
            checks++;
            if ({an, num, digit_idx, frame_done} !== e) begin
                fails++;
                $display("FAIL two_loads t=%0d got an=%b num=%h idx=%0d fd=%b exp an=%b num=%h idx=%0d fd=%b",
                         mt, an, num, digit_idx, frame_done, e[10:7], e[6:3], e[2:1], e[0]);
            end
        end
        for (int i = 0; i < 64; i++) begin
            drive_cycle((i < 32) && (mt % FRAME == FRAME - 1), 16'h00C7);
            e = sb.pop_front();
            checks++;
            if ({an, num, digit_idx, frame_done} !== e) begin
                fails++;
                $display("FAIL boundary_load t=%0d got an=%b num=%h idx=%0d fd=%b exp an=%b num=%h idx=%0d fd=%b",
                         mt, an, num, digit_idx, frame_done, e[10:7], e[6:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        lz_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drive_cycle(mt % FRAME == 3, 16'h9999);
            e = sb.pop_front();
            checks++;
            if ({an, num, digit_idx, frame_done} !== e) begin
                fails++;
                $display("FAIL pre_reset t=%0d got an=%b num=%h idx=%0d fd=%b exp an=%b num=%h idx=%0d fd=%b",
                         mt, an, num, digit_idx, frame_done, e[10:7], e[6:3], e[2:1], e[0]);
            end
            if (mpend && (mt % FRAME == 21)) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            fails++;
            $display("FAIL reset_mid_setup got no pending load at slot 2 cnt 5 exp one within 100 cycles");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({an, num, digit_idx, frame_done} !== {4'hF, 4'hF, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_async got an=%b num=%h idx=%0d fd=%b exp an=1111 num=f idx=0 fd=0",
                     an, num, digit_idx, frame_done);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb.push_back(exp_at(0, mdisp, lz_en));
        e = sb.pop_front();
        checks++;
        if ({an, num, digit_idx, frame_done} !== e) begin
            fails++;
            $display("FAIL reset_mid_release got %b exp %b", {an, num, digit_idx, frame_done}, e);
        end
        for (int i = 0; i < 45; i++) begin
            drive_cycle(1'b0, 16'h0);
            e = sb.pop_front();
            checks++;
            if ({an, num, digit_idx, frame_done} !== e) begin
                fails++;
                $display("FAIL post_reset t=%0d got an=%b num=%h idx=%0d fd=%b exp an=%b num=%h idx=%0d fd=%b",
                         mt, an, num, digit_idx, frame_done, e[10:7], e[6:3], e[2:1], e[0]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, exp finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_leading_zero();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
